// File: rtl/display_sched_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared constants and types for the display scheduler slice:
//   - digit count / digit width / frame width of the serial display
//   - request bus address width and the blink-mask register addresses
//   - write-request bundle produced by the arbitration mux
// ---------------------------------------------------------------------------
package display_pkg;

  localparam int DIGITS  = 9;
  localparam int DIGIT_W = 8;
  localparam int FRAME_W = DIGITS * DIGIT_W;
  localparam int ADDR_W  = 4;
  localparam int FCNT_W  = 3;

  // Control addresses above the digit range.
  localparam logic [ADDR_W-1:0] ADDR_BLINK_LO = 4'd9;
  localparam logic [ADDR_W-1:0] ADDR_BLINK_HI = 4'd10;

  // Single write selected by the arbiter for the current cycle.
  typedef struct packed {
    logic               vld;
    logic [ADDR_W-1:0]  addr;
    logic [DIGIT_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/display_sched_if.sv
// ---------------------------------------------------------------------------
// display_sched_if
// Two-requester write bus into the display scheduler.
//   a_valid/a_addr/a_data : requester A write request (held until a_ready)
//   a_ready               : grant to A; transfer = a_valid & a_ready
//   b_*                   : identical signals for requester B
// Modports:
//   master : requester side (drives valid/addr/data, sees ready)
//   slave  : scheduler side (sees valid/addr/data, drives ready)
// ---------------------------------------------------------------------------
interface display_sched_if;
  import display_pkg::*;

  logic               a_valid;
  logic [ADDR_W-1:0]  a_addr;
  logic [DIGIT_W-1:0] a_data;
  logic               a_ready;

  logic               b_valid;
  logic [ADDR_W-1:0]  b_addr;
  logic [DIGIT_W-1:0] b_data;
  logic               b_ready;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready
  );

endinterface

// File: rtl/display_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter.
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   i_valid : request vector, bit 0 = A, bit 1 = B
//   o_grant : one-hot (or zero) grant vector, combinational from i_valid
//             and the last-grant register
// A lone request is always granted. When both request, the requester that
// did not win the previous transfer is granted. Because a grant is only
// ever issued to a valid requester, every grant is a transfer, so the
// last-grant register moves only when some grant is issued. It resets to
// B so that A wins the first contested cycle.
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  logic r_last_b;
  logic w_gnt_a;
  logic w_gnt_b;

  always_comb begin
    w_gnt_a = i_valid[0] & (~i_valid[1] | r_last_b);
    w_gnt_b = i_valid[1] & (~i_valid[0] | ~r_last_b);
  end

  assign o_grant = {w_gnt_b, w_gnt_a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
    end else if (w_gnt_a | w_gnt_b) begin
      r_last_b <= w_gnt_b;
    end
  end

endmodule

// File: rtl/display_sched.sv
// ---------------------------------------------------------------------------
// display_sched
// Double-buffered frame scheduler for a serial 7-segment display shifter.
// Two requesters write digits into a shadow buffer through a round-robin
// arbiter; once per refresh period the shadow is copied into the active
// frame that drives the shifter, so the shifter never sees a frame change
// in the middle of a shift.
//
// Parameters:
//   REFRESH_BITS : refresh timer width; commit period = 2^REFRESH_BITS cycles
//   DIGITS       : number of 8-bit digits (7 segments + DP)
// Ports:
//   clk          : sole clock, rising edge
//   rst_n        : asynchronous active-low reset
//   bus          : display_sched_if.slave write bus (requesters A and B)
//   display_bits : active frame, digit d at bits [8d+7:8d]
//   frame_tick   : one-cycle pulse in the first cycle of each new frame
//   o_frame_cnt  : 3-bit count of commits, wrapping 7->0
// Configuration:
//   DISPLAY_SCHED_BLINK_EN : when defined, adds a per-digit blink mask
//   (addr 9 -> mask[7:0], addr 10 -> mask[8] from data[0]). Masked digits
//   are blanked in commits taken while frame counter bit 2 is set.
//   When undefined, addr 9/10 writes are accepted and ignored.
// ---------------------------------------------------------------------------
module display_sched
  import display_pkg::*;
#(
  parameter int REFRESH_BITS = 17,
  parameter int DIGITS       = display_pkg::DIGITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  display_sched_if.slave              bus,
  output logic [DIGITS*DIGIT_W-1:0]   display_bits,
  output logic                        frame_tick,
  output logic [FCNT_W-1:0]           o_frame_cnt
);

  localparam int FW = DIGITS * DIGIT_W;

  // -------------------------------------------------------------------------
  // Arbitration and write mux
  // -------------------------------------------------------------------------
  logic [1:0] w_grant;
  wr_req_t    w_wr;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid ({bus.b_valid, bus.a_valid}),
    .o_grant (w_grant)
  );

  assign bus.a_ready = w_grant[0];
  assign bus.b_ready = w_grant[1];

  always_comb begin
    w_wr.vld  = |w_grant;
    w_wr.addr = w_grant[1] ? bus.b_addr : bus.a_addr;
    w_wr.data = w_grant[1] ? bus.b_data : bus.a_data;
  end

  // -------------------------------------------------------------------------
  // Refresh timer: the all-ones cycle is the commit (terminal) cycle
  // -------------------------------------------------------------------------
  logic [REFRESH_BITS-1:0] r_timer;
  logic                    w_terminal;

  assign w_terminal = &r_timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + REFRESH_BITS'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Blink mask (optional) and commit transform
  // -------------------------------------------------------------------------
  logic [FCNT_W-1:0] r_fcnt;
  logic [FW-1:0]     r_shadow;
  logic [FW-1:0]     r_active;
  logic              r_tick;
  logic [FW-1:0]     w_commit;

`ifdef DISPLAY_SCHED_BLINK_EN
  logic [DIGITS-1:0] r_mask;

  // Blank masked digits when the blink phase is set.
  function automatic logic [FW-1:0] f_commit(
    input logic [FW-1:0]     shadow,
    input logic [DIGITS-1:0] mask,
    input logic              blank
  );
    logic [FW-1:0] f_frame;
    f_frame = shadow;
    for (int d = 0; d < DIGITS; d++) begin
      if (blank && mask[d]) begin
        f_frame[d*DIGIT_W +: DIGIT_W] = '0;
      end
    end
    return f_frame;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
    end else if (w_wr.vld) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (d < 8 && w_wr.addr == ADDR_BLINK_LO) begin
          r_mask[d] <= w_wr.data[d % DIGIT_W];
        end
        if (d == 8 && w_wr.addr == ADDR_BLINK_HI) begin
          r_mask[d] <= w_wr.data[0];
        end
      end
    end
  end

  // Phase comes from the frame counter before this commit's increment:
  // four visible frames, then four blanked frames.
  assign w_commit = f_commit(r_shadow, r_mask, r_fcnt[FCNT_W-1]);
`else
  assign w_commit = r_shadow;
`endif

  // -------------------------------------------------------------------------
  // Shadow buffer, active frame, frame tick and frame counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_tick   <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      // Commit samples the shadow as it was at the start of the terminal
      // cycle; a write in that same cycle only reaches the shadow.
      if (w_terminal) begin
        r_active <= w_commit;
        r_fcnt   <= r_fcnt + FCNT_W'(1);
      end
      r_tick <= w_terminal;

      // Addresses beyond the digit range never match here, so control
      // and unused addresses are accepted without touching the shadow.
      if (w_wr.vld) begin
        for (int d = 0; d < DIGITS; d++) begin
          if (w_wr.addr == ADDR_W'(d)) begin
            r_shadow[d*DIGIT_W +: DIGIT_W] <= w_wr.data;
          end
        end
      end
    end
  end

  assign display_bits = r_active;
  assign frame_tick   = r_tick;
  assign o_frame_cnt  = r_fcnt;

endmodule

// File: tb/tb_display_sched.sv
// ---------------------------------------------------------------------------
// tb_display_sched
// Self-checking bench for display_sched with REFRESH_BITS = 4 (16-cycle
// frame). A behavioural model tracks digits as byte arrays, counts cycles
// since reset release and commits, and derives the arbitration winner from
// "whoever did not win last". Directed scenarios compare against constants;
// the random scenario compares against the model every cycle.
// ---------------------------------------------------------------------------
module tb_display_sched;

  localparam int RB     = 4;
  localparam int PERIOD = 16;
  localparam int ND     = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] display_bits;
  logic        frame_tick;
  logic [2:0]  frame_cnt;

  int n_pass  = 0;
  int n_total = 0;

  display_sched_if u_if ();

  display_sched #(.REFRESH_BITS(RB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (u_if),
    .display_bits (display_bits),
    .frame_tick   (frame_tick),
    .o_frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  byte unsigned m_shadow [ND];
  byte unsigned m_active [ND];
`ifdef DISPLAY_SCHED_BLINK_EN
  bit [8:0] m_mask;
`endif
  int m_n;
  int m_commits;
  bit m_tick;
  bit m_last_b;

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_shadow[d] = 8'h00;
      m_active[d] = 8'h00;
    end
`ifdef DISPLAY_SCHED_BLINK_EN
    m_mask = '0;
`endif
    m_n       = 0;
    m_commits = 0;
    m_tick    = 1'b0;
    m_last_b  = 1'b1;
  endtask

  function automatic logic [71:0] model_frame();
    logic [71:0] f;
    f = '0;
    for (int d = 0; d < ND; d++) f[d*8 +: 8] = m_active[d];
    return f;
  endfunction

  // One clock edge of the model; win = 0 none, 1 A, 2 B.
  task automatic model_step(input logic av, input logic [3:0] aa, input logic [7:0] ad,
                            input logic bv, input logic [3:0] ba, input logic [7:0] bd,
                            output int win);
    int   addr;
    logic [7:0] data;
    bit   blank;
    win = 0;
    if (av && bv) win = m_last_b ? 1 : 2;
    else if (av) win = 1;
    else if (bv) win = 2;
    if ((m_n % PERIOD) == PERIOD - 1) begin
      blank = ((m_commits % 8) >= 4);
      for (int d = 0; d < ND; d++) begin
`ifdef DISPLAY_SCHED_BLINK_EN
        m_active[d] = (blank && m_mask[d]) ? 8'h00 : m_shadow[d];
`else
        m_active[d] = m_shadow[d];
`endif
      end
      m_commits++;
      m_tick = 1'b1;
    end else begin
      m_tick = 1'b0;
    end
    if (win != 0) begin
      addr = (win == 1) ? int'(aa) : int'(ba);
      data = (win == 1) ? ad : bd;
      if (addr < ND) m_shadow[addr] = data;
`ifdef DISPLAY_SCHED_BLINK_EN
      else if (addr == 9) m_mask[7:0] = data;
      else if (addr == 10) m_mask[8] = data[0];
`endif
      m_last_b = (win == 2);
    end
    m_n++;
  endtask

  // ---------------- stimulus primitives ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic do_cycle(input logic av, input logic [3:0] aa, input logic [7:0] ad,
                          input logic bv, input logic [3:0] ba, input logic [7:0] bd,
                          output logic ra, output logic rb, output int win);
    u_if.a_valid = av; u_if.a_addr = aa; u_if.a_data = ad;
    u_if.b_valid = bv; u_if.b_addr = ba; u_if.b_data = bd;
    #1;
    ra = u_if.a_ready;
    rb = u_if.b_ready;
    @(posedge clk);
    model_step(av, aa, ad, bv, ba, bd, win);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic ra, rb;
    int   w;
    for (int i = 0; i < n; i++) do_cycle(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, ra, rb, w);
  endtask

  task automatic reset_release();
    @(negedge clk);
    @(negedge clk);
    u_if.a_valid = 1'b0;
    u_if.b_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic fresh_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    reset_release();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    u_if.a_valid = 1'b0; u_if.a_addr = '0; u_if.a_data = '0;
    u_if.b_valid = 1'b0; u_if.b_addr = '0; u_if.b_data = '0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (display_bits !== 72'h0) $display("FAIL reset_display: got %h want 0", display_bits); else n_pass++;
    n_total++; if (frame_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", frame_tick); else n_pass++;
    n_total++; if (frame_cnt !== 3'd0) $display("FAIL reset_fcnt: got %0d want 0", frame_cnt); else n_pass++;
    n_total++; if ({u_if.b_ready, u_if.a_ready} !== 2'b00)
      $display("FAIL reset_idle_ready: got %b want 00", {u_if.b_ready, u_if.a_ready}); else n_pass++;
    reset_release();
  endtask

  task automatic test_first_write();
    logic ra, rb;
    int   w;
    logic [7:0] want_d;
    logic       want_t;
    fresh_reset();
    for (int c = 0; c <= 17; c++) begin
      if (c == 2) begin
        do_cycle(1'b1, 4'd0, 8'h3F, 1'b0, 4'd0, 8'h00, ra, rb, w);
        n_total++; if (ra !== 1'b1) $display("FAIL first_write_ready: got %b want 1", ra); else n_pass++;
      end else begin
        do_cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, ra, rb, w);
      end
      want_t = (c + 1 == 16);
      want_d = (c + 1 >= 16) ? 8'h3F : 8'h00;
      n_total++; if (frame_tick !== want_t)
        $display("FAIL first_write_tick cyc%0d: got %b want %b", c + 1, frame_tick, want_t); else n_pass++;
      n_total++; if (display_bits[7:0] !== want_d)
        $display("FAIL first_write_digit0 cyc%0d: got %h want %h", c + 1, display_bits[7:0], want_d); else n_pass++;
    end
  endtask

  task automatic test_arbitration();
    logic ra, rb;
    int   w;
    logic [7:0] ad, bd, last_a, last_b;
    logic [1:0] want;
    fresh_reset();
    last_a = 8'h00; last_b = 8'h00;
    for (int k = 0; k < 8; k++) begin
      ad = 8'($urandom_range(0, 255));
      bd = 8'($urandom_range(0, 255));
      do_cycle(1'b1, 4'd1, ad, 1'b1, 4'd2, bd, ra, rb, w);
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_total++; if ({rb, ra} !== want)
        $display("FAIL arb_grant k%0d: got %b want %b", k, {rb, ra}, want); else n_pass++;
      if (want == 2'b01) last_a = ad; else last_b = bd;
    end
    idle(8);
    n_total++; if (display_bits[15:8] !== last_a)
      $display("FAIL arb_digit1: got %h want %h", display_bits[15:8], last_a); else n_pass++;
    n_total++; if (display_bits[23:16] !== last_b)
      $display("FAIL arb_digit2: got %h want %h", display_bits[23:16], last_b); else n_pass++;
    n_total++; if (frame_cnt !== 3'd1) $display("FAIL arb_fcnt: got %0d want 1", frame_cnt); else n_pass++;
  endtask

  task automatic test_terminal_write();
    logic ra, rb;
    int   w;
    fresh_reset();
    idle(15);
    do_cycle(1'b1, 4'd4, 8'h66, 1'b0, 4'd0, 8'h00, ra, rb, w);
    n_total++; if (frame_tick !== 1'b1) $display("FAIL term_tick1: got %b want 1", frame_tick); else n_pass++;
    n_total++; if (display_bits[39:32] !== 8'h00)
      $display("FAIL term_digit4_c1: got %h want 00", display_bits[39:32]); else n_pass++;
    idle(15);
    n_total++; if (display_bits[39:32] !== 8'h00)
      $display("FAIL term_digit4_mid: got %h want 00", display_bits[39:32]); else n_pass++;
    idle(1);
    n_total++; if (frame_tick !== 1'b1) $display("FAIL term_tick2: got %b want 1", frame_tick); else n_pass++;
    n_total++; if (display_bits[39:32] !== 8'h66)
      $display("FAIL term_digit4_c2: got %h want 66", display_bits[39:32]); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic ra, rb;
    int   w;
    logic want_t;
    fresh_reset();
    for (int d = 0; d < ND; d++)
      do_cycle(1'b1, 4'(d), 8'($urandom_range(1, 255)), 1'b0, 4'd0, 8'h00, ra, rb, w);
    idle(7);
    n_total++; if (display_bits !== model_frame())
      $display("FAIL midrst_loaded: got %h want %h", display_bits, model_frame()); else n_pass++;
    idle(5);
    u_if.a_valid = 1'b1; u_if.a_addr = 4'd3; u_if.a_data = 8'h55;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (display_bits !== 72'h0) $display("FAIL midrst_async_clear: got %h want 0", display_bits); else n_pass++;
    n_total++; if (frame_cnt !== 3'd0) $display("FAIL midrst_fcnt: got %0d want 0", frame_cnt); else n_pass++;
    reset_release();
    for (int c = 0; c <= 16; c++) begin
      idle(1);
      want_t = (c + 1 == 16);
      n_total++; if (frame_tick !== want_t)
        $display("FAIL midrst_tick cyc%0d: got %b want %b", c + 1, frame_tick, want_t); else n_pass++;
    end
    n_total++; if (display_bits !== 72'h0)
      $display("FAIL midrst_discard: got %h want 0", display_bits); else n_pass++;
  endtask

  task automatic test_blink();
    logic ra, rb;
    int   w;
    logic [7:0] want;
    fresh_reset();
    do_cycle(1'b1, 4'd9,  8'h01, 1'b0, 4'd0, 8'h00, ra, rb, w);
    do_cycle(1'b1, 4'd10, 8'h00, 1'b0, 4'd0, 8'h00, ra, rb, w);
    do_cycle(1'b1, 4'd0,  8'hFF, 1'b0, 4'd0, 8'h00, ra, rb, w);
    idle(13);
    for (int k = 1; k <= 10; k++) begin
`ifdef DISPLAY_SCHED_BLINK_EN
      want = (((k - 1) % 8) < 4) ? 8'hFF : 8'h00;
`else
      want = 8'hFF;
`endif
      n_total++; if (display_bits[7:0] !== want)
        $display("FAIL blink_commit%0d: got %h want %h", k, display_bits[7:0], want); else n_pass++;
      idle(16);
    end
  endtask

  task automatic test_ignored_addr();
    logic ra, rb;
    int   w;
    logic [71:0] want;
    want = 72'h5A << 40;
    fresh_reset();
    do_cycle(1'b1, 4'd5, 8'h5A, 1'b0, 4'd0, 8'h00, ra, rb, w);
    do_cycle(1'b1, 4'd13, 8'hAA, 1'b0, 4'd0, 8'h00, ra, rb, w);
    n_total++; if (ra !== 1'b1) $display("FAIL ign_ready13: got %b want 1", ra); else n_pass++;
    do_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd11, 8'h77, ra, rb, w);
    n_total++; if (rb !== 1'b1) $display("FAIL ign_ready11: got %b want 1", rb); else n_pass++;
    do_cycle(1'b1, 4'd15, 8'hC3, 1'b0, 4'd0, 8'h00, ra, rb, w);
    idle(12);
    n_total++; if (display_bits !== want) $display("FAIL ign_commit1: got %h want %h", display_bits, want); else n_pass++;
    do_cycle(1'b1, 4'd13, 8'hAA, 1'b0, 4'd0, 8'h00, ra, rb, w);
    idle(15);
    n_total++; if (display_bits !== want) $display("FAIL ign_commit2: got %h want %h", display_bits, want); else n_pass++;
  endtask

  task automatic test_random();
    logic ra, rb;
    int   w;
    logic av, bv;
    logic [3:0] aa, ba;
    logic [7:0] ad, bd;
    logic [1:0] want_r;
    fresh_reset();
    av = 1'b0; bv = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
    for (int i = 0; i < 400; i++) begin
      // A requester only changes its request once it has been granted.
      if (!av) begin
        av = ($urandom_range(0, 2) != 0);
        aa = 4'($urandom_range(0, 15));
        ad = 8'($urandom_range(0, 255));
      end
      if (!bv) begin
        bv = ($urandom_range(0, 2) != 0);
        ba = 4'($urandom_range(0, 15));
        bd = 8'($urandom_range(0, 255));
      end
      do_cycle(av, aa, ad, bv, ba, bd, ra, rb, w);
      want_r = (w == 1) ? 2'b01 : (w == 2) ? 2'b10 : 2'b00;
      n_total++; if ({rb, ra} !== want_r)
        $display("FAIL rand_ready i%0d: got %b want %b", i, {rb, ra}, want_r); else n_pass++;
      n_total++; if (display_bits !== model_frame())
        $display("FAIL rand_frame i%0d: got %h want %h", i, display_bits, model_frame()); else n_pass++;
      n_total++; if (frame_tick !== m_tick)
        $display("FAIL rand_tick i%0d: got %b want %b", i, frame_tick, m_tick); else n_pass++;
      n_total++; if (frame_cnt !== 3'(m_commits % 8))
        $display("FAIL rand_fcnt i%0d: got %0d want %0d", i, frame_cnt, m_commits % 8); else n_pass++;
      if (w == 1) av = 1'b0;
      if (w == 2) bv = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_arbitration();
    test_terminal_write();
    test_reset_midframe();
    test_blink();
    test_ignored_addr();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/display_sched.md
DISPLAY_SCHED -- requirements
Module: display_sched

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 17: refresh timer width; commit period = 2^REFRESH_BITS cycles, aligned with the serial display shifter frame.
REQ-002 SHALL have parameter DIGITS, default 9: digits of 8 bits each (7-seg plus DP); frame width = 8*DIGITS = 72.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a_valid  input  1  requester A write request.
REQ-006 a_addr  input  4  requester A address: 0..8 digit, 9..15 control/ignored.
REQ-007 a_data  input  8  requester A write data.
REQ-008 a_ready  output  1  requester A grant; transfer when a_valid & a_ready.
REQ-009 b_valid, b_addr, b_data, b_ready  same widths/meaning for requester B.
REQ-010 display_bits  output  72  active frame to the shifter; digit d at bits [8d+7:8d].
REQ-011 frame_tick  output  1  one-cycle pulse in the cycle a new display_bits value first appears.

Function
REQ-012 SHALL keep a 72-bit shadow buffer (write target) and a 72-bit active register (drives display_bits).
REQ-013 At most one transfer per cycle; a_ready/b_ready SHALL be combinational from valids and last-grant state, never both high.
REQ-014 Only one valid -> grant it; both valid -> grant the requester not granted last; last-grant updates only on a transfer.
REQ-015 Requester SHALL hold valid/addr/data stable until ready; ready with valid low is not a transfer.
REQ-016 Transfer to addr 0..8 SHALL write data into the shadow digit on the next edge; addr 11..15 accepted with no effect.
REQ-017 Refresh timer SHALL count up, wrapping at all-ones; terminal cycle = timer all-ones.
REQ-018 On the terminal cycle, active <= shadow as held at the start of that cycle; a same-cycle write lands in shadow and shows at the following commit.
REQ-019 frame_tick SHALL be registered, high exactly the cycle after each terminal cycle, regardless of data change.
REQ-020 display_bits SHALL never change except at a commit edge (no tearing mid-shift).
REQ-021 3-bit frame counter SHALL increment at each commit, wrapping 7->0.

Reset
REQ-022 rst_n low SHALL immediately clear shadow, active, blink mask, timer, frame counter, frame_tick; display_bits = 0.
REQ-023 Last-grant SHALL reset to B, so A wins the first contested cycle.
REQ-024 Reset mid-transfer SHALL discard the write; ready outputs follow REQ-014 from reset state.

Configuration
REQ-025 Macro DISPLAY_SCHED_BLINK_EN SHALL compile in a 9-bit blink mask.
REQ-026 With it: addr 9 writes mask[7:0], addr 10 writes mask[8] from data[0]; at commit, if the pre-increment frame counter bit 2 is 1, masked digits load 8'h00 into active, else shadow value.
REQ-027 Without it: addr 9/10 accepted with no effect; no mask storage; commit always copies shadow unchanged.

Structure
REQ-028 Package display_pkg SHALL hold DIGITS, digit width 8, address constants (ADDR_BLINK_LO=9, ADDR_BLINK_HI=10), frame width.
REQ-029 Arbitration SHALL be sub-module rr_arb2 (two-requester round-robin, valid in, grant out, transfer-qualified last-grant state).

Verification (bench uses REFRESH_BITS=4, period 16)
REQ-030 Reset, A writes addr 0 data 8'h3F at cycle 2 -> display_bits[7:0]=8'h3F from cycle 16, frame_tick high cycle 16 only.
REQ-031 A and B valid every cycle, addrs 1 and 2 -> grants alternate A,B,A,B; first grant A; one transfer per cycle.
REQ-032 Write addr 4 data 8'h66 exactly on terminal cycle -> not visible at that commit; visible at next commit, 16 cycles later.
REQ-033 rst_n pulsed low mid-frame with digits loaded -> display_bits=0 asynchronously; timer restarts; next frame_tick 16 cycles after release.
REQ-034 BLINK_EN: mask=9'h001, digit0=8'hFF -> digit0 reads 8'hFF for commits 1-4, 8'h00 for commits 5-8, repeating; without macro always 8'hFF.
REQ-035 Write addr 13 data 8'hAA -> ready asserted, frame unchanged at next commit.
